hour24_to_12_conv: RTL and testbench

//  Converts a BCD 24-hour value (00-23) from the clock's hour counter into 12-hour BCD (01-12)

---
 rtl/hour24_to_12_conv_pkg.sv | 26 ++
 rtl/hour24_to_12_conv_if.sv | 23 ++
 rtl/hour24_to_12_conv_bcd_hour_sub12.sv | 26 ++
 rtl/hour24_to_12_conv.sv | 92 +++++++++
 tb/tb_hour24_to_12_conv.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/hour24_to_12_conv_pkg.sv
// Shared constants and helpers for the 24-hour to 12-hour BCD hour converter.
// Also used by the optional input register stage (macro T24T12_INPUT_REG_EN).
package hour24_to_12_conv_pkg;

    localparam logic [7:0] HOUR_NOON     = 8'h12;
    localparam logic [7:0] HOUR_MIDNIGHT = 8'h00;
    localparam logic [7:0] HOUR_MAX      = 8'h23;

    localparam int LINE_PM     = 0;
    localparam int LINE_AM     = 1;
    localparam int LINE_TWELVE = 2;
    localparam int LINE_ERR    = 3;

    // Digit-wise check: both nibbles must be decimal and the hour must not exceed HOUR_MAX.
    function automatic logic bcd_hour_valid(input logic [7:0] hour);
        logic tens_ok;
        logic units_ok;
        logic range_ok;
        tens_ok  = (hour[7:4] <= HOUR_MAX[7:4]);
        units_ok = (hour[3:0] <= 4'd9);
        range_ok = (hour[7:4] < HOUR_MAX[7:4]) ||
                   ((hour[7:4] == HOUR_MAX[7:4]) && (hour[3:0] <= HOUR_MAX[3:0]));
        return tens_ok && units_ok && range_ok;
    endfunction

endpackage

// File: rtl/hour24_to_12_conv_if.sv
// Hour bus between the hour counter (master) and the converter (slave).
interface hour24_to_12_conv_if;

    logic       Trans;
    logic [7:0] Hour24;
    logic [7:0] Hour12;
    logic [3:0] Line;

    modport master (
        output Trans,
        output Hour24,
        input  Hour12,
        input  Line
    );

    modport slave (
        input  Trans,
        input  Hour24,
        output Hour12,
        output Line
    );

endinterface

// File: rtl/hour24_to_12_conv_bcd_hour_sub12.sv
// Combinational BCD subtract-12 for hours 13..23; result is 01..11 in BCD.
module bcd_hour_sub12 (
    input  logic [7:0] hour_in,
    output logic [7:0] hour_out
);

    logic [3:0] units_s;
    logic       borrow_s;
    logic [3:0] tens_s;

    // Subtract 2 from the units digit with decimal borrow, then 1 (+borrow) from the tens digit.
    always_comb begin
        units_s  = 4'd0;
        borrow_s = 1'b0;
        if (hour_in[3:0] >= 4'd2) begin
            units_s  = hour_in[3:0] - 4'd2;
            borrow_s = 1'b0;
        end else begin
            units_s  = hour_in[3:0] + 4'd8;
            borrow_s = 1'b1;
        end
        tens_s   = hour_in[7:4] - 4'd1 - {3'd0, borrow_s};
        hour_out = {tens_s, units_s};
    end

endmodule

// File: rtl/hour24_to_12_conv.sv
// 24-hour to 12-hour BCD hour converter with AM/PM/twelve/error indicators, registered outputs.
// Macro T24T12_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module hour24_to_12_conv
    import hour24_to_12_conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    hour24_to_12_conv_if.slave       bus
);

    logic       trans_s;
    logic [7:0] hour_s;
    logic [7:0] sub_s;
    logic       valid_s;
    logic       is_am_s;
    logic [7:0] hour12_s;
    logic [3:0] line_s;
    logic [7:0] hour12_r;
    logic [3:0] line_r;

`ifdef T24T12_INPUT_REG_EN
    logic       trans_r;
    logic [7:0] hour24_r;

    // Input capture stage; cleared together with the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            trans_r  <= 1'b0;
            hour24_r <= 8'h00;
        end else begin
            trans_r  <= bus.Trans;
            hour24_r <= bus.Hour24;
        end
    end

    assign trans_s = trans_r;
    assign hour_s  = hour24_r;
`else
    assign trans_s = bus.Trans;
    assign hour_s  = bus.Hour24;
`endif

    bcd_hour_sub12 u_sub12 (
        .hour_in  (hour_s),
        .hour_out (sub_s)
    );

    assign valid_s = bcd_hour_valid(hour_s);
    assign is_am_s = (hour_s[7:4] == 4'd0) ||
                     ((hour_s[7:4] == 4'd1) && (hour_s[3:0] <= 4'd1));

    // Validity check and mode mux; error overrides everything and leaves [2:0] clear.
    always_comb begin
        hour12_s = 8'h00;
        line_s   = 4'b0000;
        if (!valid_s) begin
            hour12_s         = 8'h00;
            line_s[LINE_ERR] = 1'b1;
        end else if (!trans_s) begin
            hour12_s = hour_s;
        end else if (hour_s == HOUR_MIDNIGHT) begin
            hour12_s            = HOUR_NOON;
            line_s[LINE_AM]     = 1'b1;
            line_s[LINE_TWELVE] = 1'b1;
        end else if (is_am_s) begin
            hour12_s        = hour_s;
            line_s[LINE_AM] = 1'b1;
        end else if (hour_s == HOUR_NOON) begin
            hour12_s            = HOUR_NOON;
            line_s[LINE_PM]     = 1'b1;
            line_s[LINE_TWELVE] = 1'b1;
        end else begin
            hour12_s        = sub_s;
            line_s[LINE_PM] = 1'b1;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hour12_r <= 8'h00;
            line_r   <= 4'b0000;
        end else begin
            hour12_r <= hour12_s;
            line_r   <= line_s;
        end
    end

    assign bus.Hour12 = hour12_r;
    assign bus.Line   = line_r;

endmodule

// File: tb/tb_hour24_to_12_conv.sv
// Self-checking bench for hour24_to_12_conv: directed steps plus random stimulus vs. an arithmetic model.
module tb_hour24_to_12_conv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    hour24_to_12_conv_if bus ();

    hour24_to_12_conv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model of the optional input stage: what the converter core sees when T24T12_INPUT_REG_EN is set.
    bit       prev_trans = 1'b0;
    bit [7:0] prev_hour  = 8'h00;

    // Reference: decode BCD to an integer hour, convert with modulo arithmetic, re-encode.
    function automatic void ref_model(input bit t, input bit [7:0] h,
                                      output bit [7:0] o, output bit [3:0] l);
        int tens;
        int units;
        int n;
        int d;
        tens  = int'(h[7:4]);
        units = int'(h[3:0]);
        n     = tens * 10 + units;
        if (tens > 9 || units > 9 || n > 23) begin
            o = 8'h00;
            l = 4'b1000;
        end else if (!t) begin
            o = h;
            l = 4'b0000;
        end else begin
            d = (n % 12 == 0) ? 12 : (n % 12);
            o = {4'(d / 10), 4'(d % 10)};
            l = {1'b0, (d == 12), (n < 12), (n >= 12)};
        end
    endfunction

    // Apply one cycle of inputs, then check the outputs 1 time unit after the edge.
    task automatic step(input bit r, input bit t, input bit [7:0] h, input string tag);
        bit [7:0] exp_h;
        bit [3:0] exp_l;
        rst        = r;
        bus.Trans  = t;
        bus.Hour24 = h;
        @(posedge clk);
        #1;
        if (r) begin
            exp_h = 8'h00;
            exp_l = 4'b0000;
        end else begin
`ifdef T24T12_INPUT_REG_EN
            ref_model(prev_trans, prev_hour, exp_h, exp_l);
`else
            ref_model(t, h, exp_h, exp_l);
`endif
        end
        prev_trans = r ? 1'b0 : t;
        prev_hour  = r ? 8'h00 : h;

        tests++;
        assert (bus.Hour12 === exp_h) else begin
            fails++;
            $error("FAIL %s hour12: got %h expected %h (trans=%0b in=%h)", tag, bus.Hour12, exp_h, t, h);
        end
        tests++;
        assert (bus.Line === exp_l) else begin
            fails++;
            $error("FAIL %s line: got %b expected %b (trans=%0b in=%h)", tag, bus.Line, exp_l, t, h);
        end
        tests++;
        assert (!(bus.Line[1] && bus.Line[0]) && !(bus.Line[3] && (bus.Line[2:0] != 3'b000))) else begin
            fails++;
            $error("FAIL %s line_invariant: got %b expected exclusive AM/PM and clean error", tag, bus.Line);
        end
    endtask

    initial begin
        bit [7:0] h;
        bit [7:0] sweep_h;
        bus.Trans  = 1'b0;
        bus.Hour24 = 8'h00;

        // Reset held for two cycles with a live input.
        step(1'b1, 1'b1, 8'h15, "reset0");
        step(1'b1, 1'b1, 8'h15, "reset1");

        // Passthrough.
        step(1'b0, 1'b0, 8'h17, "pass17");
        step(1'b0, 1'b0, 8'h17, "pass17b");

        // Full sweep in 12-hour mode.
        for (int i = 0; i < 24; i++) begin
            sweep_h = {4'(i / 10), 4'(i % 10)};
            step(1'b0, 1'b1, sweep_h, "sweep");
        end
        step(1'b0, 1'b1, 8'h00, "sweep_flush");

        // Boundaries.
        step(1'b0, 1'b1, 8'h11, "bnd11");
        step(1'b0, 1'b1, 8'h12, "bnd12");
        step(1'b0, 1'b1, 8'h13, "bnd13");
        step(1'b0, 1'b1, 8'h22, "bnd22");
        step(1'b0, 1'b1, 8'h23, "bnd23");

        // Invalid inputs in both modes.
        step(1'b0, 1'b1, 8'h24, "inv24");
        step(1'b0, 1'b0, 8'h24, "inv24p");
        step(1'b0, 1'b1, 8'h1A, "inv1A");
        step(1'b0, 1'b0, 8'h1A, "inv1Ap");
        step(1'b0, 1'b1, 8'h30, "inv30");
        step(1'b0, 1'b0, 8'h30, "inv30p");
        step(1'b0, 1'b1, 8'hFF, "invFF");

        // Mode toggle with fixed hour 20.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, bit'(i % 2), 8'h20, "toggle");
        end

        // Mid-stream reset and recovery.
        step(1'b0, 1'b1, 8'h19, "pre_rst");
        step(1'b1, 1'b1, 8'h19, "mid_rst");
        step(1'b0, 1'b1, 8'h19, "post_rst0");
        step(1'b0, 1'b1, 8'h05, "post_rst1");

        // Random stimulus: mostly legal hours, some arbitrary bytes, rare resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                h = 8'($urandom_range(0, 255));
            end else begin
                h = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            end
            step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), h, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
